// File: rtl/mem_seq_ctrl.sv
// mem_seq_ctrl: sequences multi-word access to the on-chip ledger RAM.
// Three phases: INIT writes the starting image to every word, READ/CAPTURE loads every word
// into the datapath registers, WRITE stores the processed words back after process_done.
//
// Ports:
//   i_clock, i_reset         : clock and synchronous active-high reset
//   i_init_memory            : request init phase (sampled in IDLE, wins over load)
//   i_load_memory            : request read phase (sampled in IDLE, only after init)
//   i_process_done           : datapath finished, start write-back (sampled in PROC)
//   i_init_data, i_wb_data   : write data sources for the current word_sel
//   o_mem_addr, o_mem_wdata  : RAM address and write data
//   o_mem_we                 : RAM write enable
//   o_word_sel               : current word index (same as o_mem_addr)
//   o_load_registers         : one-cycle capture strobe for word o_word_sel
//   o_busy, o_done           : not-idle flag / idle-and-initialised flag
//   o_finished_init          : sticky init-complete flag, cleared only by reset
//   o_op_complete            : one-cycle pulse when write-back finishes
`timescale 1ns / 1ps

module mem_seq_ctrl #(
  parameter int unsigned DATA_W     = 48,
  parameter int unsigned ADDR_W     = 2,
  parameter int unsigned NUM_WORDS  = 4,
  parameter int unsigned INIT_WAIT  = 15,
  parameter int unsigned READ_WAIT  = 7,
  parameter int unsigned WRITE_WAIT = 7
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_init_memory,
  input  logic              i_load_memory,
  input  logic              i_process_done,
  input  logic [DATA_W-1:0] i_init_data,
  input  logic [DATA_W-1:0] i_wb_data,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_word_sel,
  output logic              o_load_registers,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_finished_init,
  output logic              o_op_complete
);

  localparam int unsigned MAX_WAIT =
      (INIT_WAIT > READ_WAIT) ? ((INIT_WAIT > WRITE_WAIT) ? INIT_WAIT : WRITE_WAIT)
                              : ((READ_WAIT > WRITE_WAIT) ? READ_WAIT : WRITE_WAIT);
  localparam int unsigned WAIT_W = $clog2(MAX_WAIT) + 1;

  localparam logic [WAIT_W-1:0] INIT_LAST  = WAIT_W'(INIT_WAIT - 1);
  localparam logic [WAIT_W-1:0] READ_LAST  = WAIT_W'(READ_WAIT - 1);
  localparam logic [WAIT_W-1:0] WRITE_LAST = WAIT_W'(WRITE_WAIT - 1);
  localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StRead,
    StCapture,
    StProc,
    StWrite
  } state_e;

  state_e            r_state;
  logic [WAIT_W-1:0] r_wait;
  logic [ADDR_W-1:0] r_idx;
  logic              r_mem_we;
  logic              r_load_registers;
  logic              r_busy;
  logic              r_done;
  logic              r_finished_init;
  logic              r_op_complete;
  logic              w_sel_init;

  // Outputs are registered alongside every state change, so each transition below also sets
  // the output values that belong to the state being entered.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state          <= StIdle;
      r_wait           <= '0;
      r_idx            <= '0;
      r_mem_we         <= 1'b0;
      r_load_registers <= 1'b0;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_finished_init  <= 1'b0;
      r_op_complete    <= 1'b0;
    end else begin
      // Strobes default low; only the entering transition raises them.
      r_load_registers <= 1'b0;
      r_op_complete    <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (i_init_memory) begin
            r_state  <= StInit;
            r_idx    <= '0;
            r_wait   <= '0;
            r_mem_we <= 1'b1;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
          end else if (i_load_memory && r_finished_init) begin
            r_state <= StRead;
            r_idx   <= '0;
            r_wait  <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end
        end
        StInit: begin
          if (r_wait == INIT_LAST) begin
            r_wait <= '0;
            if (r_idx == LAST_IDX) begin
              r_state         <= StIdle;
              r_idx           <= '0;
              r_mem_we        <= 1'b0;
              r_busy          <= 1'b0;
              r_done          <= 1'b1;
              r_finished_init <= 1'b1;
            end else begin
              r_idx <= r_idx + ADDR_W'(1);
            end
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end
        StRead: begin
          if (r_wait == READ_LAST) begin
            r_state          <= StCapture;
            r_wait           <= '0;
            r_load_registers <= 1'b1;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end
        StCapture: begin
          r_wait <= '0;
          if (r_idx == LAST_IDX) begin
            r_state <= StProc;
            r_idx   <= '0;
          end else begin
            r_state <= StRead;
            r_idx   <= r_idx + ADDR_W'(1);
          end
        end
        StProc: begin
          if (i_process_done) begin
            r_state  <= StWrite;
            r_idx    <= '0;
            r_wait   <= '0;
            r_mem_we <= 1'b1;
          end
        end
        StWrite: begin
          if (r_wait == WRITE_LAST) begin
            r_wait <= '0;
            if (r_idx == LAST_IDX) begin
              r_state       <= StIdle;
              r_idx         <= '0;
              r_mem_we      <= 1'b0;
              r_busy        <= 1'b0;
              r_done        <= r_finished_init;
              r_op_complete <= 1'b1;
            end else begin
              r_idx <= r_idx + ADDR_W'(1);
            end
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end
        default: begin
          r_state  <= StIdle;
          r_idx    <= '0;
          r_wait   <= '0;
          r_mem_we <= 1'b0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  // Write data source follows the registered state; IDLE presents init_data.
  always_comb begin
    w_sel_init  = (r_state == StIdle) || (r_state == StInit);
    o_mem_wdata = w_sel_init ? i_init_data : i_wb_data;
  end

  assign o_mem_addr       = r_idx;
  assign o_word_sel       = r_idx;
  assign o_mem_we         = r_mem_we;
  assign o_load_registers = r_load_registers;
  assign o_busy           = r_busy;
  assign o_done           = r_done;
  assign o_finished_init  = r_finished_init;
  assign o_op_complete    = r_op_complete;

endmodule

// File: tb/tb_mem_seq_ctrl.sv
// Scoreboard bench for mem_seq_ctrl: stimulus pushes expected RAM writes, capture strobes and
// completion pulses (with their cycle numbers) into a queue; a negedge monitor pops and compares.
// A second instance covers the NUM_WORDS=1 / short-wait parameter override.
`timescale 1ns / 1ps

module tb_mem_seq_ctrl;

  localparam logic [47:0] INIT_BASE = 48'h1111_2222_3300;
  localparam logic [47:0] WB_VAL    = 48'h0000_00AB_CDEF;
  localparam logic [1:0]  K_W = 2'd1, K_L = 2'd2, K_O = 2'd3;

  typedef struct packed {
    logic        dut;
    logic [1:0]  kind;
    logic [31:0] cyc;
    logic [1:0]  addr;
    logic [47:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  ev_t  exp_q[$];

  logic        init1, load1, pd1, we1, lr1, busy1, done1, fin1, opc1;
  logic [1:0]  addr1, ws1;
  logic [47:0] idata1, wdata1;
  logic        init2, load2, pd2, we2, lr2, busy2, done2, fin2, opc2;
  logic [1:0]  addr2, ws2;
  logic [47:0] idata2, wdata2;

  // Starting image depends on the word being written, as the RAM-side mux would present it.
  assign idata1 = INIT_BASE | {46'b0, ws1};
  assign idata2 = INIT_BASE | {46'b0, ws2};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_seq_ctrl u_dut (
    .i_clock(clk), .i_reset(rst), .i_init_memory(init1), .i_load_memory(load1),
    .i_process_done(pd1), .i_init_data(idata1), .i_wb_data(WB_VAL),
    .o_mem_addr(addr1), .o_mem_wdata(wdata1), .o_mem_we(we1), .o_word_sel(ws1),
    .o_load_registers(lr1), .o_busy(busy1), .o_done(done1), .o_finished_init(fin1),
    .o_op_complete(opc1)
  );

  mem_seq_ctrl #(
    .NUM_WORDS(1), .INIT_WAIT(2), .READ_WAIT(1), .WRITE_WAIT(1)
  ) u_dut_small (
    .i_clock(clk), .i_reset(rst), .i_init_memory(init2), .i_load_memory(load2),
    .i_process_done(pd2), .i_init_data(idata2), .i_wb_data(WB_VAL),
    .o_mem_addr(addr2), .o_mem_wdata(wdata2), .o_mem_we(we2), .o_word_sel(ws2),
    .o_load_registers(lr2), .o_busy(busy2), .o_done(done2), .o_finished_init(fin2),
    .o_op_complete(opc2)
  );

  task automatic check_ev(input logic d, input logic we, input logic lr, input logic oc,
                          input logic [1:0] a, input logic [47:0] wd);
    ev_t act;
    ev_t e;
    if (!(we || lr || oc)) return;
    act.dut  = d;
    act.kind = we ? K_W : (lr ? K_L : K_O);
    act.cyc  = cyc;
    act.addr = a;
    act.data = we ? wd : 48'h0;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL sb_unexpected act=%h exp=none", act);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        bad++;
        $display("FAIL sb_event act=%h exp=%h", act, e);
      end
    end
  endtask

  always @(negedge clk) begin
    check_ev(1'b0, we1, lr1, opc1, addr1, wdata1);
    check_ev(1'b1, we2, lr2, opc2, addr2, wdata2);
  end

  task automatic push(input logic d, input logic [1:0] k, input int c, input logic [1:0] a,
                      input logic [47:0] data);
    ev_t e;
    e.dut  = d;
    e.kind = k;
    e.cyc  = c;
    e.addr = a;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) step();
  endtask

  // Init phase on the default instance; with_load also raises load_memory in the same cycle.
  task automatic do_init1(input logic with_load);
    int c;
    c = cyc;
    init1 = 1'b1;
    load1 = with_load;
    for (int k = 0; k < 60; k++)
      push(1'b0, K_W, c + 1 + k, 2'(k / 15), INIT_BASE | 48'(k / 15));
    step();
    init1 = 1'b0;
    load1 = 1'b0;
    chk("init_busy", 64'(busy1), 64'd1);
    wait_to(c + 61);
    chk("init_fin", 64'(fin1), 64'd1);
    chk("init_done", 64'(done1), 64'd1);
    chk("init_idle", 64'(busy1), 64'd0);
  endtask

  task automatic do_read1();
    int r;
    r = cyc;
    load1 = 1'b1;
    for (int k = 0; k < 4; k++) push(1'b0, K_L, r + 8 + 8 * k, 2'(k), 48'h0);
    step();
    load1 = 1'b0;
    wait_to(r + 33);
    chk("proc_busy", 64'(busy1), 64'd1);
    chk("proc_we", 64'(we1), 64'd0);
    chk("proc_ws", 64'(ws1), 64'd0);
  endtask

  task automatic chk_reset_idle(input string tag);
    chk({tag, "_busy"}, 64'(busy1), 64'd0);
    chk({tag, "_we"}, 64'(we1), 64'd0);
    chk({tag, "_fin"}, 64'(fin1), 64'd0);
    chk({tag, "_ws"}, 64'(ws1), 64'd0);
    chk({tag, "_done"}, 64'(done1), 64'd0);
  endtask

  initial begin
    int p;
    int r;
    int c;
    rst = 1'b1;
    {init1, load1, pd1, init2, load2, pd2} = '0;
    repeat (3) step();
    chk("rst_we", 64'(we1), 64'd0);
    chk("rst_lr", 64'(lr1), 64'd0);
    chk("rst_opc", 64'(opc1), 64'd0);
    chk("rst_addr", 64'(addr1), 64'd0);
    chk("rst_wdata", 64'(wdata1), 64'(INIT_BASE));
    chk_reset_idle("rst");
    rst = 1'b0;
    step();

    // load_memory before any init is ignored.
    load1 = 1'b1;
    step();
    step();
    chk("noinit_busy", 64'(busy1), 64'd0);
    load1 = 1'b0;
    step();
    chk("noinit_busy2", 64'(busy1), 64'd0);

    // Full init, read, 20 idle PROC cycles, write-back.
    do_init1(1'b0);
    do_read1();
    repeat (20) step();
    chk("proc_hold_busy", 64'(busy1), 64'd1);
    p = cyc;
    pd1 = 1'b1;
    for (int k = 0; k < 28; k++) push(1'b0, K_W, p + 1 + k, 2'(k / 7), WB_VAL);
    push(1'b0, K_O, p + 29, 2'd0, 48'h0);
    step();
    pd1 = 1'b0;
    wait_to(p + 29);
    chk("wb_opc", 64'(opc1), 64'd1);
    chk("wb_done", 64'(done1), 64'd1);
    chk("wb_busy", 64'(busy1), 64'd0);
    step();
    chk("wb_opc_pulse", 64'(opc1), 64'd0);

    // Simultaneous init and load: init wins.
    do_init1(1'b1);

    // Reset in the middle of reading word 2.
    r = cyc;
    load1 = 1'b1;
    push(1'b0, K_L, r + 8, 2'd0, 48'h0);
    push(1'b0, K_L, r + 16, 2'd1, 48'h0);
    step();
    load1 = 1'b0;
    wait_to(r + 19);
    chk("rd_mid_ws", 64'(ws1), 64'd2);
    rst = 1'b1;
    step();
    chk_reset_idle("rst_rd");
    rst = 1'b0;
    step();

    // Reset in the middle of writing word 1.
    do_init1(1'b0);
    do_read1();
    p = cyc;
    pd1 = 1'b1;
    for (int k = 0; k < 11; k++) push(1'b0, K_W, p + 1 + k, 2'(k / 7), WB_VAL);
    step();
    pd1 = 1'b0;
    wait_to(p + 11);
    chk("wr_mid_ws", 64'(ws1), 64'd1);
    rst = 1'b1;
    step();
    chk_reset_idle("rst_wr");
    rst = 1'b0;
    step();

    // Single-word instance with minimal waits.
    c = cyc;
    init2 = 1'b1;
    push(1'b1, K_W, c + 1, 2'd0, INIT_BASE);
    push(1'b1, K_W, c + 2, 2'd0, INIT_BASE);
    step();
    init2 = 1'b0;
    wait_to(c + 3);
    chk("s_fin", 64'(fin2), 64'd1);
    chk("s_idle", 64'(busy2), 64'd0);
    r = cyc;
    load2 = 1'b1;
    push(1'b1, K_L, r + 2, 2'd0, 48'h0);
    step();
    load2 = 1'b0;
    wait_to(r + 3);
    chk("s_proc_busy", 64'(busy2), 64'd1);
    chk("s_proc_addr", 64'(addr2), 64'd0);
    step();
    p = cyc;
    pd2 = 1'b1;
    push(1'b1, K_W, p + 1, 2'd0, WB_VAL);
    push(1'b1, K_O, p + 2, 2'd0, 48'h0);
    step();
    pd2 = 1'b0;
    wait_to(p + 2);
    chk("s_opc", 64'(opc2), 64'd1);
    chk("s_done", 64'(done2), 64'd1);
    chk("s_addr", 64'(addr2), 64'd0);

    repeat (3) step();
    chk("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_seq_ctrl.md
Name: mem_seq_ctrl

Overview:
- Parametrised successor to the single-word ledger memory controller. Sequences multi-word access to the on-chip ledger RAM.
- Three phases:
  - Initialisation: writes the starting image into every word.
  - Read: loads every word into the datapath registers.
  - Write-back: writes every word back after the datapath finishes processing.
- Sits between the top-level game/transaction FSM and the RAM. Wait counts are configurable so the same block serves any RAM latency.

Parameters:
- DATA_W, 48, width of one memory word
- ADDR_W, 2, address/word-select width
- NUM_WORDS, 4, words handled per phase (1..2**ADDR_W)
- INIT_WAIT, 15, cycles mem_we held per word during init (>=1)
- READ_WAIT, 7, cycles address held before capture per word (>=1)
- WRITE_WAIT, 7, cycles mem_we held per word during write-back (>=1)

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- init_memory  in  1  request init phase (sampled in IDLE)
- load_memory  in  1  request read phase (sampled in IDLE)
- process_done  in  1  datapath finished, start write-back (sampled in PROC)
- init_data  in  DATA_W  starting word for current word_sel
- wb_data  in  DATA_W  datapath write-back word for current word_sel
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_we  out  1  RAM write enable
- word_sel  out  ADDR_W  current word index (same value as mem_addr)
- load_registers  out  1  one-cycle capture strobe for word word_sel
- busy  out  1  high in any state except IDLE
- done  out  1  high in IDLE when finished_init=1
- finished_init  out  1  sticky: set at end of INIT, cleared only by reset
- op_complete  out  1  one-cycle pulse on WRITE to IDLE transition

Behaviour:
- Clocking and reset:
  - One clock domain.
  - reset has priority over everything, including mid-phase.
  - Reset state: IDLE, word index 0, wait counter 0, finished_init=0.
- Output values during and after reset:
  - 0: mem_we, load_registers, op_complete, busy, done.
  - mem_addr=0 and word_sel=0.
  - mem_wdata=init_data (combinational mux, see below).
- States: IDLE, INIT, READ, CAPTURE, PROC, WRITE.
- Counters:
  - One wait counter, width $clog2(max wait)+1. Cleared on every state or word change.
  - One word index, ADDR_W bits. Never exceeds NUM_WORDS-1; no wrap into unused addresses.
- IDLE:
  - init_memory=1: go to INIT, index 0. init_memory wins if asserted with load_memory in the same cycle.
  - Else load_memory=1 and finished_init=1: go to READ, index 0.
  - load_memory while finished_init=0 is ignored.
- INIT:
  - mem_we=1, mem_wdata=init_data.
  - Per word, hold INIT_WAIT cycles. On the last cycle, index+1.
  - After word NUM_WORDS-1: set finished_init, go to IDLE.
- READ:
  - mem_we=0, address held READ_WAIT cycles, then go to CAPTURE.
- CAPTURE:
  - One cycle, load_registers=1.
  - If index < NUM_WORDS-1: index+1, back to READ. Else go to PROC, index 0.
- PROC:
  - Outputs idle, busy=1.
  - Wait for process_done=1, then go to WRITE, index 0.
  - process_done in any other state is ignored.
- WRITE:
  - mem_we=1, mem_wdata=wb_data.
  - Per word, hold WRITE_WAIT cycles.
  - After the last word: go to IDLE, op_complete=1 for one cycle.
- Request handling while not IDLE:
  - init_memory and load_memory are ignored.
  - No queuing; the requester holds its level.
- Output decoding:
  - All outputs are decoded from registered state and counters (Moore).
  - mem_wdata mux: init_data in INIT and IDLE, wb_data otherwise.
- Phase latencies:
  - Init: NUM_WORDS*INIT_WAIT cycles (60 at defaults).
  - Read: NUM_WORDS*(READ_WAIT+1) cycles (32 at defaults).
  - Write: NUM_WORDS*WRITE_WAIT cycles (28 at defaults).

Test Plan:
- Reset, pulse init_memory for one cycle.
  - mem_we=1 for exactly 60 cycles, mem_addr stepping 0,1,2,3 every 15 cycles.
  - Then finished_init=1, done=1, busy=0.
- After init, pulse load_memory.
  - load_registers high on cycles 8, 16, 24, 32 after entry, with word_sel 0,1,2,3.
  - mem_we=0 throughout; then PROC, busy=1.
- In PROC, hold process_done low 20 cycles: no writes.
  - Then assert process_done with wb_data=48'h0000_00AB_CDEF.
  - mem_we=1 for 28 cycles with addresses 0..3, data = wb_data.
  - op_complete pulses once; done returns 1.
- load_memory before any init: stays IDLE, busy=0.
- init_memory and load_memory asserted in the same IDLE cycle: INIT is entered.
- reset asserted mid-READ (word 2) and mid-WRITE (word 1).
  - Next cycle: IDLE, mem_we=0, finished_init=0, word_sel=0.
- Parameter override NUM_WORDS=1, READ_WAIT=1, WRITE_WAIT=1.
  - Read phase = 2 cycles, write phase = 1 cycle.
  - mem_addr stays 0 throughout.
